flash_sequencer: RTL
====================

Name: flash_sequencer

Overview:
Command sequencer in front of pmod_sf3_driver. It turns single-word user requests (read byte, program byte, sector erase) into the SPI flash command sequences the driver executes one at a time: WREN, then PP or SE, then RDSR polling until WIP clears. It sits between the game/memory subsystem logic and the driver instance, and owns all of the driver's control inputs.

Parameters:
POLL_GAP, 64, idle clk cycles between successive RDSR transactions
POLL_MAX, 16'd50000, maximum RDSR polls before declaring timeout
GAP_W, 8, width of gap counter; must satisfy POLL_GAP < 2**GAP_W

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  1  request strobe; sampled only while busy=0
op  in  2  00=READ (03h), 01=PROGRAM (06h then 02h), 10=ERASE (06h then 20h), 11=reserved
req_addr  in  24  flash byte/sector address
req_wdata  in  8  program data
busy  out  1  high from the cycle after req is accepted until ack
ack  out  1  one-cycle pulse when the operation completes (also on error)
err  out  1  valid with ack: 1 = poll timeout or reserved op
rdata  out  8  read result; valid with ack for READ, holds until next READ ack
drv_start  out  1  one-cycle start pulse to the driver
drv_cmd  out  8  driver opcode
drv_addr  out  24  driver address
drv_data  out  8  driver write byte
drv_len  out  8  driver data length (always 1)
drv_done  in  1  driver completion
drv_rdata  in  8  driver data_out

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; counters 0; latched op/addr/wdata cleared.
- Accept: in IDLE with req=1, latch op, req_addr, and req_wdata; busy=1 from the next cycle. req is ignored while busy.
- op=11: go to FIN with err=1, with no driver activity.
- States: IDLE, ISSUE, WAIT, GAP, FIN.
- ISSUE: drive drv_cmd/addr/data/len for the current step, with drv_start=1 for exactly one cycle, then WAIT. drv_cmd/addr/data/len hold stable until the next ISSUE.
- WAIT: the first cycle after ISSUE ignores drv_done as a guard against a stale level. Afterwards, drv_done=1 ends the step.
- Step list:
  - READ: 03h with addr, then FIN.
  - PROGRAM: 06h, then 02h with addr/wdata, then RDSR(05h)…, then FIN.
  - ERASE: 06h, then 20h with addr, then RDSR…, then FIN.
  - For 06h and 05h, drv_addr=0 and drv_data=0.
- READ completion: rdata <= drv_rdata on drv_done.
- RDSR completion, drv_rdata[0] (WIP):
  - WIP=0: FIN, err=0.
  - WIP=1: increment poll_cnt. If poll_cnt reaches POLL_MAX, go to FIN with err=1. Otherwise go to GAP, count POLL_GAP cycles, then ISSUE another 05h.
- FIN: ack=1 and busy=0 in the same cycle; return to IDLE. A req in the cycle after ack is accepted. poll_cnt clears on accept.
- Minimum latency, req to ack: READ = 1 (accept) + 1 (ISSUE) + driver time + 1 (FIN).
- Reset mid-operation: immediate return to IDLE with outputs zeroed. The flash may still be internally busy; the user must re-issue.
- drv_done asserted in IDLE or GAP is ignored.

Decomposition:
- Shared package (flash_pkg): opcode constants CMD_WREN=06h, CMD_PP=02h, CMD_READ=03h, CMD_SE=20h, CMD_RDSR=05h; op encodings; state encoding.
- Sub-modules: none needed; the gap and poll counters stay inline. The top-level instantiates flash_sequencer alongside pmod_sf3_driver.

Test Plan:
Each scenario drives a behavioural driver model that pulses drv_done N cycles after drv_start.
1. Reset mid-READ: assert reset during WAIT -> all outputs 0 immediately; the next READ completes normally.
2. READ addr=000010h, model returns A5h -> exactly one start with cmd=03h, addr=000010h; then ack=1, err=0, rdata=A5h; busy deasserts with ack.
3. PROGRAM addr=000001h, data=55h, WIP returns 1,1,0 -> starts issued in order 06h, 02h(000001h, 55h), 05h, 05h, 05h; ≥POLL_GAP cycles between 05h starts; ack with err=0.
4. ERASE with WIP stuck at 1, POLL_MAX=4 -> 06h, 20h, then exactly 4×05h; ack with err=1.
5. op=11 -> ack within 3 cycles, err=1, no drv_start; req pulsed while busy during scenario 3 -> ignored, no extra starts.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared opcodes, request encodings and state types for the SPI flash command sequencer.
package flash_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_SE   = 8'h20;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_PROG  = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_FIN
  } state_t;

  // Position within an operation's command list.
  typedef enum logic [1:0] {
    STEP_FIRST,
    STEP_MAIN,
    STEP_POLL
  } step_t;

  function automatic logic [7:0] step_cmd(input op_t op, input step_t step);
    logic [7:0] cmd;
    case (step)
      STEP_FIRST: cmd = (op == OP_READ) ? CMD_READ : CMD_WREN;
      STEP_MAIN:  cmd = (op == OP_ERASE) ? CMD_SE : CMD_PP;
      default:    cmd = CMD_RDSR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/flash_sequencer.sv
// Expands single-word read/program/erase requests into the WREN / PP|SE / RDSR-poll
// command sequence for the SPI flash driver, one driver transaction at a time.
module flash_sequencer
  import flash_pkg::*;
#(
  parameter int          POLL_GAP = 64,
  parameter logic [15:0] POLL_MAX = 16'd50000,
  parameter int          GAP_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        drv_start,
  output logic [7:0]  drv_cmd,
  output logic [23:0] drv_addr,
  output logic [7:0]  drv_data,
  output logic [7:0]  drv_len,
  input  logic        drv_done,
  input  logic [7:0]  drv_rdata
);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  state_t           state;
  op_t              op_q;
  step_t            step;
  logic [23:0]      addr_q;
  logic [7:0]       wdata_q;
  logic             first_wait;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      poll_cnt;
  logic [7:0]       cur_cmd;
  logic [15:0]      poll_inc;

  assign cur_cmd  = step_cmd(op_q, step);
  assign poll_inc = poll_cnt + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_READ;
      step       <= STEP_FIRST;
      addr_q     <= '0;
      wdata_q    <= '0;
      first_wait <= 1'b0;
      gap_cnt    <= '0;
      poll_cnt   <= '0;
      busy       <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      drv_start  <= 1'b0;
      drv_cmd    <= '0;
      drv_addr   <= '0;
      drv_data   <= '0;
      drv_len    <= '0;
    end else begin
      drv_start <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_q     <= op_t'(op);
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            step     <= STEP_FIRST;
            poll_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (op_q == OP_RSVD) begin
            ack   <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_FIN;
          end else begin
            // Only the addressed commands carry an address; only PP carries data.
            drv_start  <= 1'b1;
            drv_cmd    <= cur_cmd;
            drv_addr   <= (cur_cmd == CMD_WREN || cur_cmd == CMD_RDSR) ? 24'd0 : addr_q;
            drv_data   <= (cur_cmd == CMD_PP) ? wdata_q : 8'd0;
            drv_len    <= 8'd1;
            first_wait <= 1'b1;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          first_wait <= 1'b0;
          // drv_done in the start cycle may be a leftover level from the previous step.
          if (!first_wait && drv_done) begin
            case (step)
              STEP_FIRST: begin
                if (op_q == OP_READ) begin
                  rdata <= drv_rdata;
                  ack   <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_FIN;
                end else begin
                  step  <= STEP_MAIN;
                  state <= ST_ISSUE;
                end
              end
              STEP_MAIN: begin
                step  <= STEP_POLL;
                state <= ST_ISSUE;
              end
              default: begin
                if (!drv_rdata[0]) begin
                  ack   <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_FIN;
                end else begin
                  poll_cnt <= poll_inc;
                  if (poll_inc >= POLL_MAX) begin
                    ack   <= 1'b1;
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_FIN;
                  end else begin
                    gap_cnt <= '0;
                    state   <= ST_GAP;
                  end
                end
              end
            endcase
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_ISSUE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
